// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared mode encoding for the multi-mode flip-flop bank.
package ff_bank_pkg;

  typedef logic [1:0] ff_mode_t;

  localparam ff_mode_t MODE_SR = 2'b00;
  localparam ff_mode_t MODE_JK = 2'b01;
  localparam ff_mode_t MODE_D  = 2'b10;
  localparam ff_mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/multi_mode_ff_bank_cell.sv
// One bank bit: SR/JK/D/T cell with a count-mode toggle request that beats en.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     en,
  input  ff_mode_t mode,
  input  logic     a,
  input  logic     b,
  input  logic     tog,
  output logic     q
);

  logic nxt;
  logic s_jk;
  logic r_jk;

  // JK is realised as an SR cell with S=J&~q, R=K&q; SR itself is reset-dominant.
  always_comb begin
    nxt  = q;
    s_jk = a & ~q;
    r_jk = b & q;
    case (mode)
      MODE_SR: begin
        if (b)      nxt = 1'b0;
        else if (a) nxt = 1'b1;
      end
      MODE_JK: begin
        if (r_jk)      nxt = 1'b0;
        else if (s_jk) nxt = 1'b1;
      end
      MODE_D:  nxt = a;
      default: nxt = q ^ a;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)   q <= RST_BIT;
    else if (tog) q <= ~q;
    else if (en)  q <= nxt;
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit SR/JK/D/T flip-flop bank with up/down count mode.
// Optional sticky S=R=1 detector enabled by FF_BANK_SR_ILLEGAL_EN.
module multi_mode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_en,
  input  logic             cnt_dn,
  input  logic             clr_illegal,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             carry,
  output logic             sr_illegal
);

  logic [WIDTH-1:0] tog;
  logic             wrap;
  logic             cell_en;
  logic             run;

  assign cell_en = en & ~cnt_en;
  assign qbar    = ~q;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); run ends as the wrap condition.
  always_comb begin
    tog = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tog[i] = cnt_en & run;
      run    = run & (cnt_dn ? ~q[i] : q[i]);
    end
    // A single-bit counter reports carry on every count edge in either direction.
    wrap = cnt_en & (run | (WIDTH == 1));
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_BIT(RESET_VAL[i])
    ) u_cell (
      .clock(clock),
      .reset(reset),
      .en   (cell_en),
      .mode (mode),
      .a    (a[i]),
      .b    (b[i]),
      .tog  (tog[i]),
      .q    (q[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) carry <= 1'b0;
    else        carry <= wrap;
  end

`ifdef FF_BANK_SR_ILLEGAL_EN
  logic sr_hit;

  assign sr_hit = en & ~cnt_en & (mode == MODE_SR) & (|(a & b));

  always_ff @(posedge clock) begin
    if (!reset)           sr_illegal <= 1'b0;
    else if (sr_hit)      sr_illegal <= 1'b1;
    else if (clr_illegal) sr_illegal <= 1'b0;
  end
`else
  logic unused_clr_illegal;

  assign unused_clr_illegal = clr_illegal;
  assign sr_illegal         = 1'b0;
`endif

endmodule
